// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and line/parity constants for the TX and RX paths.
// The STOP2 state exists only when UART_TX_TWO_STOP_EN is defined.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        STOP   = 3'd4,
        STOP2  = 3'd5
`else
        STOP   = 3'd4
`endif
    } uart_state_e;
    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational even/odd parity of a data word, shared by the TX framer and RX checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_o
);
    always_comb par_o = (^data_i) ^ (par_typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, start / data LSB-first / optional parity / stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [DATA_WIDTH-1:0] div_ratio,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int IDX_W = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] div_cnt_q, div_cnt_d, div_eff_q, div_eff_d, shift_q;
    logic [IDX_W-1:0]      bit_idx_q;
    logic                  par_en_q, par_bit_q, par_d, tx_q, busy_q, tc;
    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data_i    (p_data),
        .par_typ_i (par_typ),
        .par_o     (par_d)
    );
    always_comb begin
        tc        = div_cnt_q == div_eff_q - 1'b1;
        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        div_eff_d = div_ratio == '0 ? DATA_WIDTH'(1) : div_ratio;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            div_eff_q <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (data_valid) begin
                state_q   <= START;
                div_cnt_q <= '0;
                div_eff_q <= div_eff_d;
                shift_q   <= p_data;
                bit_idx_q <= '0;
                par_en_q  <= par_en;
                par_bit_q <= par_d;
                tx_q      <= ~IDLE_LEVEL;
                busy_q    <= 1'b1;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            if (tc) begin
                // tx_q is loaded on the same edge the state advances, so every bit lasts div_eff clocks
                case (state_q)
                    START: begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                    end
                    DATA: begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            tx_q    <= par_en_q ? par_bit_q : IDLE_LEVEL;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        tx_q    <= IDLE_LEVEL;
                    end
`ifdef UART_TX_TWO_STOP_EN
                    STOP: state_q <= STOP2;
                    STOP2: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
    assign tx_out = tx_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench; stimulus queues expected frames, a monitor checks tx_out/busy per bit.
module tb_uart_tx_frame;
    logic       clk = 0, rst = 1, data_valid = 0, par_en = 0, par_typ = 0;
    logic [7:0] p_data = 0, div_ratio = 0;
    logic       tx_out, busy;
    int         checks = 0, errors = 0, cyc = 0;
    bit         mon_en = 0, mon_busy = 0;
    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
        bit          b2b;
        logic [7:0]  data;
    } exp_t;
    exp_t q[$];
    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid), .par_en(par_en),
        .par_typ(par_typ), .div_ratio(div_ratio), .tx_out(tx_out), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic void expect_frame(input logic [7:0] d, input logic pe, input logic pbit,
                                         input int de, input bit b2b);
        exp_t e;
        int   n;
        e.bits = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
        n = 9;
        if (pe) begin
            e.bits[n] = pbit;
            n++;
        end
        n++;
`ifdef UART_TX_TWO_STOP_EN
        n++;
`endif
        e.nbits = n;
        e.div = de;
        e.b2b = b2b;
        e.data = d;
        q.push_back(e);
    endfunction
    // Monitor: a busy rising edge marks the first start-bit clock of a frame
    initial begin
        logic prev = 0;
        int   end_cyc = -100;
        forever begin
            @(negedge clk);
            if (mon_en && busy && !prev) begin
                mon_busy = 1;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: frame started at cycle %0d with nothing queued", cyc);
                    while (busy) @(negedge clk);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.b2b) check("b2b_gap_start_cycle", cyc, end_cyc + 1);
                    for (int i = 0; i < e.nbits; i++) begin
                        bit   ok = 1;
                        logic bad_tx = 0, bad_busy = 0;
                        for (int j = 0; j < e.div; j++) begin
                            if (i != 0 || j != 0) @(negedge clk);
                            if (ok && (tx_out !== e.bits[i] || busy !== 1'b1)) begin
                                ok = 0;
                                bad_tx = tx_out;
                                bad_busy = busy;
                            end
                        end
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL frame_%02h_bit%0d: tx_out=%b busy=%b, required tx_out=%b busy=1",
                                     e.data, i, bad_tx, bad_busy, e.bits[i]);
                        end
                    end
                    @(negedge clk);
                    check($sformatf("frame_%02h_end_busy", e.data), busy, 0);
                    check($sformatf("frame_%02h_end_tx", e.data), tx_out, 1);
                    end_cyc = cyc;
                end
                mon_busy = 0;
            end
            prev = busy;
        end
    end
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [7:0] dr,
                        input logic pbit, input int de);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; div_ratio = dr; data_valid = 1;
        expect_frame(d, pe, pbit, de, 0);
        @(negedge clk);
        data_valid = 0;
    endtask
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || mon_busy || q.size() != 0) && n < 3000);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_done: timeout busy=%b queued=%0d", busy, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask
    initial begin
        bit hi = 1;
        repeat (3) @(negedge clk);
        check("reset_tx_out", tx_out, 1);
        check("reset_busy", busy, 0);
        rst = 0;
        // Reset mid-frame, monitor disabled
        @(negedge clk);
        p_data = 8'hA5; div_ratio = 4; data_valid = 1;
        @(negedge clk);
        data_valid = 0;
        check("pre_reset_busy", busy, 1);
        repeat (6) @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check("abort_tx_out", tx_out, 1);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_out !== 1 || busy !== 0) hi = 0;
        end
        check("post_reset_line_idle", hi, 1);
        mon_en = 1;
        // Basic frame and parity variants
        send(8'hA5, 0, 0, 8'd4, 0, 4);
        wait_done();
        send(8'h07, 1, 0, 8'd2, 1, 2);
        wait_done();
        send(8'h07, 1, 1, 8'd2, 0, 2);
        wait_done();
        // data_valid during busy is dropped
        send(8'hA5, 0, 0, 8'd4, 0, 4);
        repeat (3) @(negedge clk);
        p_data = 8'h3C; data_valid = 1;
        @(negedge clk);
        data_valid = 0;
        wait_done();
        // Back-to-back with data_valid held
        @(negedge clk);
        p_data = 8'h5A; par_en = 0; div_ratio = 3; data_valid = 1;
        expect_frame(8'h5A, 0, 0, 3, 0);
        @(negedge clk);
        p_data = 8'hC3;
        expect_frame(8'hC3, 0, 0, 3, 1);
        while (busy) @(negedge clk);
        @(negedge clk);
        data_valid = 0;
        wait_done();
        // div_ratio 0 and 1 both give one clock per bit
        send(8'h81, 0, 0, 8'd0, 0, 1);
        wait_done();
        send(8'h81, 0, 0, 8'd1, 0, 1);
        wait_done();
        // Inputs changed mid-frame do not affect it
        send(8'h96, 0, 0, 8'd4, 0, 4);
        repeat (3) @(negedge clk);
        div_ratio = 8; p_data = 8'hFF; par_en = 1;
        wait_done();
        send(8'h96, 0, 0, 8'd8, 0, 8);
        wait_done();
        // Parity with div 3: 36 clocks with two stop bits, 33 with one
        send(8'h07, 1, 0, 8'd3, 1, 3);
        wait_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
